// File: rtl/main_memory_burst.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_burst
// Purpose  : Single-port main-memory model that serves whole-line reads
//            (critical word first, wrapping inside the line) and whole-line
//            writes (sequential from the line base) for an L1 cache. Only
//            one request is outstanding at a time. Addresses beyond the
//            memory and WR_LAST framing errors are reported with ERR,
//            which is qualified by the one-cycle DONE pulse.
// Ports    : CLK, RST        - clock (rising edge), synchronous active-high reset
//            REQ_*           - request channel (valid/ready, write flag, byte addr)
//            RD_*            - read-beat channel (valid/ready, data, last)
//            WR_*            - write-beat channel (valid/ready, data, last)
//            DONE, ERR       - transaction completion pulse and error status
// Revision : 1.0 - initial release
// ============================================================================
module main_memory_burst #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_WORDS  = 2048,
    parameter int LINE_WORDS = 8,
    parameter int ACCESS_LAT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic              RD_LAST,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic              WR_LAST,
    output logic              DONE,
    output logic              ERR
);

    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam int MEM_AW     = $clog2(MEM_WORDS);
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int LINE_AW    = MEM_AW - OFF_W;
    localparam int LAT_W      = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t               state_q;
    logic                 req_ready_q;
    logic                 rd_valid_q;
    logic                 rd_last_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic                 wr_ready_q;
    logic                 done_q;
    logic                 err_q;
    logic                 err_pend_q;
    logic                 write_q;
    logic [LINE_AW-1:0]   line_q;
    logic [OFF_W-1:0]     off_q;
    logic [OFF_W-1:0]     beat_q;
    logic [LAT_W-1:0]     lat_q;

    logic [DATA_W-1:0]    mem_q [MEM_WORDS];

    // Request address decode. The word index is widened so that any
    // address bits above the memory size take part in the range check.
    logic [63:0]          w_idx_ext;
    logic                 w_req_oor;
    logic [LINE_AW-1:0]   w_req_line;
    logic [OFF_W-1:0]     w_req_off;

    assign w_idx_ext  = 64'(REQ_ADDR) >> BYTE_SHIFT;
    assign w_req_oor  = (w_idx_ext >= 64'(MEM_WORDS));
    assign w_req_line = w_idx_ext[MEM_AW-1:OFF_W];
    assign w_req_off  = w_idx_ext[OFF_W-1:0];

    // Offset of the next read beat; OFF_W-bit arithmetic gives the
    // modulo-LINE_WORDS wrap, so a burst never leaves its line.
    logic [OFF_W-1:0]     w_next_off;
    logic                 w_beat_is_last;
    logic                 w_wr_xfer;
    logic                 w_wr_mismatch;

    assign w_next_off     = off_q + beat_q + OFF_W'(1);
    assign w_beat_is_last = (beat_q == OFF_W'(LINE_WORDS - 1));
    assign w_wr_xfer      = (state_q == S_WR) && wr_ready_q && WR_VALID && !RST;
    assign w_wr_mismatch  = (WR_LAST != w_beat_is_last);

    // Storage has no reset: contents survive RST, including beats already
    // written by an interrupted burst.
    always_ff @(posedge CLK) begin
        if (w_wr_xfer) begin
            mem_q[{line_q, beat_q}] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            wr_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
            write_q     <= 1'b0;
            line_q      <= '0;
            off_q       <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        req_ready_q <= 1'b0;
                        write_q     <= REQ_WRITE;
                        line_q      <= w_req_line;
                        off_q       <= w_req_off;
                        beat_q      <= '0;
                        if (w_req_oor) begin
                            // No memory access: report straight away.
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            lat_q   <= LAT_W'(ACCESS_LAT - 1);
                            state_q <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (lat_q == '0) begin
                        if (write_q) begin
                            wr_ready_q <= 1'b1;
                            state_q    <= S_WR;
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= mem_q[{line_q, off_q}];
                            rd_last_q  <= 1'b0;
                            state_q    <= S_RD;
                        end
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end

                S_RD: begin
                    // Data and LAST only move on a transfer, which keeps
                    // them stable across RD_READY stalls.
                    if (rd_valid_q && RD_READY) begin
                        if (rd_last_q) begin
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                            err_q      <= err_pend_q;
                            state_q    <= S_RESP;
                        end else begin
                            beat_q    <= beat_q + OFF_W'(1);
                            rd_data_q <= mem_q[{line_q, w_next_off}];
                            rd_last_q <= (beat_q == OFF_W'(LINE_WORDS - 2));
                        end
                    end
                end

                S_WR: begin
                    if (w_wr_xfer) begin
                        if (w_beat_is_last) begin
                            wr_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            err_q      <= err_pend_q | w_wr_mismatch;
                            state_q    <= S_RESP;
                        end else begin
                            beat_q     <= beat_q + OFF_W'(1);
                            err_pend_q <= err_pend_q | w_wr_mismatch;
                        end
                    end
                end

                S_RESP: begin
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    err_pend_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign REQ_READY = req_ready_q;
    assign RD_VALID  = rd_valid_q;
    assign RD_LAST   = rd_last_q;
    assign RD_DATA   = rd_data_q;
    assign WR_READY  = wr_ready_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule
`default_nettype wire
